// File: rtl/l2tlb_req_ctrl.sv
// l2tlb_req_ctrl
// ---------------
// L2-side initiator for the L2 -> L2TLB translation interface. Translation
// misses from the L2 pipeline are tagged with the lowest free transaction tag,
// sent to the l2tlb through a one-entry request register, and matched against
// tagged acks. Each accepted ack is turned into a response that carries the
// original requester id. Acks may return out of order. Responses leave in ack
// order through a one-entry response register.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   miss_*                     L2 pipeline miss input (valid/retry, vpn, id)
//   l2tol2tlb_req_*            request channel to the l2tlb (valid/retry, vpn, tag)
//   l2tlbtol2_ack_*            ack channel from the l2tlb (valid/retry, tag, ppn, fault)
//   resp_*                     result channel to the L2 pipeline (valid/retry, id, ppn, fault)
//   outstanding                number of allocated tags
//   tag_err                    sticky flag: an ack arrived for an unallocated tag
module l2tlb_req_ctrl #(
    parameter int VPN_W = 27,
    parameter int PPN_W = 26,
    parameter int ID_W  = 4,
    parameter int NTAG  = 4,
    parameter int TAG_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               miss_valid,
    output logic               miss_retry,
    input  logic [VPN_W-1:0]   miss_vpn,
    input  logic [ID_W-1:0]    miss_id,
    output logic               l2tol2tlb_req_valid,
    input  logic               l2tol2tlb_req_retry,
    output logic [VPN_W-1:0]   l2tol2tlb_req_vpn,
    output logic [TAG_W-1:0]   l2tol2tlb_req_tag,
    input  logic               l2tlbtol2_ack_valid,
    output logic               l2tlbtol2_ack_retry,
    input  logic [TAG_W-1:0]   l2tlbtol2_ack_tag,
    input  logic [PPN_W-1:0]   l2tlbtol2_ack_ppn,
    input  logic               l2tlbtol2_ack_fault,
    output logic               resp_valid,
    input  logic               resp_retry,
    output logic [ID_W-1:0]    resp_id,
    output logic [PPN_W-1:0]   resp_ppn,
    output logic               resp_fault,
    output logic [TAG_W:0]     outstanding,
    output logic               tag_err
);

    localparam logic [TAG_W:0] CNT_ONE = 1;

    logic [NTAG-1:0]  alloc;
    logic [ID_W-1:0]  id_tab [NTAG];
    logic [TAG_W-1:0] free_tag;
    logic             free_any;
    logic             miss_fire;
    logic             req_drain;
    logic             ack_fire;
    logic             ack_hit;
    logic             resp_drain;

    // Lowest-index free tag. Scanning downward lets the lowest index win.
    // The scan reads the registered alloc vector. A tag freed this cycle is
    // therefore not handed out again until the next cycle.
    always_comb begin
        free_any = 1'b0;
        free_tag = '0;
        for (int i = NTAG - 1; i >= 0; i--) begin
            if (!alloc[i]) begin
                free_any = 1'b1;
                free_tag = TAG_W'(i);
            end
        end
    end

    assign miss_retry          = !free_any || (l2tol2tlb_req_valid && l2tol2tlb_req_retry);
    assign l2tlbtol2_ack_retry = resp_valid && resp_retry;

    assign miss_fire  = miss_valid && !miss_retry;
    assign req_drain  = l2tol2tlb_req_valid && !l2tol2tlb_req_retry;
    assign ack_fire   = l2tlbtol2_ack_valid && !l2tlbtol2_ack_retry;
    assign ack_hit    = ack_fire && alloc[l2tlbtol2_ack_tag];
    assign resp_drain = resp_valid && !resp_retry;

    // Tag table and outstanding count. A free and an allocate can happen in
    // the same cycle. They always touch different tags, because only an
    // allocated tag can be freed and only a free tag can be allocated.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alloc       <= '0;
            outstanding <= '0;
            for (int i = 0; i < NTAG; i++) begin
                id_tab[i] <= '0;
            end
        end else begin
            if (ack_hit) begin
                alloc[l2tlbtol2_ack_tag] <= 1'b0;
            end
            if (miss_fire) begin
                alloc[free_tag]  <= 1'b1;
                id_tab[free_tag] <= miss_id;
            end
            case ({miss_fire, ack_hit})
                2'b10:   outstanding <= outstanding + CNT_ONE;
                2'b01:   outstanding <= outstanding - CNT_ONE;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // One-entry request register. It can drain and reload in the same cycle,
    // which allows one request per cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            l2tol2tlb_req_valid <= 1'b0;
            l2tol2tlb_req_vpn   <= '0;
            l2tol2tlb_req_tag   <= '0;
        end else if (miss_fire) begin
            l2tol2tlb_req_valid <= 1'b1;
            l2tol2tlb_req_vpn   <= miss_vpn;
            l2tol2tlb_req_tag   <= free_tag;
        end else if (req_drain) begin
            l2tol2tlb_req_valid <= 1'b0;
        end
    end

    // One-entry response register. It is loaded only by acks that hit an
    // allocated tag. An ack for an unallocated tag is consumed silently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_ppn   <= '0;
            resp_fault <= 1'b0;
        end else if (ack_hit) begin
            resp_valid <= 1'b1;
            resp_id    <= id_tab[l2tlbtol2_ack_tag];
            resp_ppn   <= l2tlbtol2_ack_ppn;
            resp_fault <= l2tlbtol2_ack_fault;
        end else if (resp_drain) begin
            resp_valid <= 1'b0;
        end
    end

    // Sticky protocol error flag. Only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_err <= 1'b0;
        end else if (ack_fire && !alloc[l2tlbtol2_ack_tag]) begin
            tag_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_l2tlb_req_ctrl.sv
// tb_l2tlb_req_ctrl
// ------------------
// Self-checking bench for l2tlb_req_ctrl. A transaction-level model holds the
// following state:
//   - which tags are in use, and by which requester
//   - the single pending request and the single pending response
//   - the sticky error flag
//   - a queue of tags the emulated l2tlb has received but not yet answered
// Directed scenarios pin the model with literal expectations. A randomized
// phase then runs the DUT against the model every cycle.
module tb_l2tlb_req_ctrl;

    localparam int VPN_W = 27;
    localparam int PPN_W = 26;
    localparam int ID_W  = 4;
    localparam int NTAG  = 4;
    localparam int TAG_W = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               miss_valid;
    logic               miss_retry;
    logic [VPN_W-1:0]   miss_vpn;
    logic [ID_W-1:0]    miss_id;
    logic               l2tol2tlb_req_valid;
    logic               l2tol2tlb_req_retry;
    logic [VPN_W-1:0]   l2tol2tlb_req_vpn;
    logic [TAG_W-1:0]   l2tol2tlb_req_tag;
    logic               l2tlbtol2_ack_valid;
    logic               l2tlbtol2_ack_retry;
    logic [TAG_W-1:0]   l2tlbtol2_ack_tag;
    logic [PPN_W-1:0]   l2tlbtol2_ack_ppn;
    logic               l2tlbtol2_ack_fault;
    logic               resp_valid;
    logic               resp_retry;
    logic [ID_W-1:0]    resp_id;
    logic [PPN_W-1:0]   resp_ppn;
    logic               resp_fault;
    logic [TAG_W:0]     outstanding;
    logic               tag_err;

    always #5 clk = ~clk;

    l2tlb_req_ctrl #(
        .VPN_W(VPN_W), .PPN_W(PPN_W), .ID_W(ID_W), .NTAG(NTAG), .TAG_W(TAG_W)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .miss_valid          (miss_valid),
        .miss_retry          (miss_retry),
        .miss_vpn            (miss_vpn),
        .miss_id             (miss_id),
        .l2tol2tlb_req_valid (l2tol2tlb_req_valid),
        .l2tol2tlb_req_retry (l2tol2tlb_req_retry),
        .l2tol2tlb_req_vpn   (l2tol2tlb_req_vpn),
        .l2tol2tlb_req_tag   (l2tol2tlb_req_tag),
        .l2tlbtol2_ack_valid (l2tlbtol2_ack_valid),
        .l2tlbtol2_ack_retry (l2tlbtol2_ack_retry),
        .l2tlbtol2_ack_tag   (l2tlbtol2_ack_tag),
        .l2tlbtol2_ack_ppn   (l2tlbtol2_ack_ppn),
        .l2tlbtol2_ack_fault (l2tlbtol2_ack_fault),
        .resp_valid          (resp_valid),
        .resp_retry          (resp_retry),
        .resp_id             (resp_id),
        .resp_ppn            (resp_ppn),
        .resp_fault          (resp_fault),
        .outstanding         (outstanding),
        .tag_err             (tag_err)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    bit               m_alloc [NTAG];
    logic [ID_W-1:0]  m_id    [NTAG];
    bit               m_req_valid;
    logic [VPN_W-1:0] m_req_vpn;
    logic [TAG_W-1:0] m_req_tag;
    bit               m_resp_valid;
    logic [ID_W-1:0]  m_resp_id;
    logic [PPN_W-1:0] m_resp_ppn;
    bit               m_resp_fault;
    bit               m_tag_err;
    int               l2q[$];
    bit               miss_held;
    bit               ack_held;
    bit               allow_miss;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowestFree();
        for (int i = 0; i < NTAG; i++) begin
            if (!m_alloc[i]) return i;
        end
        return -1;
    endfunction

    function automatic int modelCount();
        int c = 0;
        for (int i = 0; i < NTAG; i++) c += int'(m_alloc[i]);
        return c;
    endfunction

    function automatic bit expMissRetry();
        return (lowestFree() < 0) || (m_req_valid && l2tol2tlb_req_retry);
    endfunction

    function automatic bit expAckRetry();
        return m_resp_valid && resp_retry;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NTAG; i++) begin
            m_alloc[i] = 1'b0;
            m_id[i]    = '0;
        end
        m_req_valid  = 1'b0;
        m_req_vpn    = '0;
        m_req_tag    = '0;
        m_resp_valid = 1'b0;
        m_resp_id    = '0;
        m_resp_ppn   = '0;
        m_resp_fault = 1'b0;
        m_tag_err    = 1'b0;
        miss_held    = 1'b0;
        ack_held     = 1'b0;
        l2q.delete();
    endtask

    task automatic idleInputs();
        miss_valid          = 1'b0;
        miss_vpn            = '0;
        miss_id             = '0;
        l2tol2tlb_req_retry = 1'b0;
        l2tlbtol2_ack_valid = 1'b0;
        l2tlbtol2_ack_tag   = '0;
        l2tlbtol2_ack_ppn   = '0;
        l2tlbtol2_ack_fault = 1'b0;
        resp_retry          = 1'b0;
    endtask

    // Advance the model by one clock, using the inputs currently applied.
    task automatic modelStep();
        int  ft;
        bit  mf, rf, af, hit, pf;
        ft  = lowestFree();
        mf  = miss_valid && !expMissRetry();
        rf  = m_req_valid && !l2tol2tlb_req_retry;
        af  = l2tlbtol2_ack_valid && !expAckRetry();
        hit = af && m_alloc[l2tlbtol2_ack_tag];
        pf  = m_resp_valid && !resp_retry;
        if (rf) l2q.push_back(int'(m_req_tag));
        if (hit) begin
            m_resp_valid = 1'b1;
            m_resp_id    = m_id[l2tlbtol2_ack_tag];
            m_resp_ppn   = l2tlbtol2_ack_ppn;
            m_resp_fault = l2tlbtol2_ack_fault;
            m_alloc[l2tlbtol2_ack_tag] = 1'b0;
            for (int k = 0; k < l2q.size(); k++) begin
                if (l2q[k] == int'(l2tlbtol2_ack_tag)) begin
                    l2q.delete(k);
                    break;
                end
            end
        end else if (pf) begin
            m_resp_valid = 1'b0;
        end
        if (af && !hit) m_tag_err = 1'b1;
        if (mf) begin
            m_alloc[ft] = 1'b1;
            m_id[ft]    = miss_id;
            m_req_valid = 1'b1;
            m_req_vpn   = miss_vpn;
            m_req_tag   = TAG_W'(ft);
        end else if (rf) begin
            m_req_valid = 1'b0;
        end
        miss_held = miss_valid && !mf;
        ack_held  = l2tlbtol2_ack_valid && !af;
    endtask

    task automatic checkRegs();
        checkOutput("req_valid", 64'(l2tol2tlb_req_valid), 64'(m_req_valid));
        if (m_req_valid) begin
            checkOutput("req_vpn", 64'(l2tol2tlb_req_vpn), 64'(m_req_vpn));
            checkOutput("req_tag", 64'(l2tol2tlb_req_tag), 64'(m_req_tag));
        end
        checkOutput("resp_valid", 64'(resp_valid), 64'(m_resp_valid));
        if (m_resp_valid) begin
            checkOutput("resp_id",    64'(resp_id),    64'(m_resp_id));
            checkOutput("resp_ppn",   64'(resp_ppn),   64'(m_resp_ppn));
            checkOutput("resp_fault", 64'(resp_fault), 64'(m_resp_fault));
        end
        checkOutput("outstanding", 64'(outstanding), 64'(modelCount()));
        checkOutput("tag_err", 64'(tag_err), 64'(m_tag_err));
    endtask

    // Inputs are set at a negedge before this is called. Combinational
    // outputs are compared just after that, then the clock advances and the
    // registered outputs are compared at the next negedge.
    task automatic tick();
        #1;
        checkOutput("miss_retry", 64'(miss_retry), 64'(expMissRetry()));
        checkOutput("ack_retry", 64'(l2tlbtol2_ack_retry), 64'(expAckRetry()));
        modelStep();
        @(posedge clk);
        @(negedge clk);
        checkRegs();
    endtask

    task automatic checkResetValues(input string pfx);
        checkOutput({pfx, "_req_valid"},   64'(l2tol2tlb_req_valid), 64'd0);
        checkOutput({pfx, "_resp_valid"},  64'(resp_valid), 64'd0);
        checkOutput({pfx, "_miss_retry"},  64'(miss_retry), 64'd0);
        checkOutput({pfx, "_ack_retry"},   64'(l2tlbtol2_ack_retry), 64'd0);
        checkOutput({pfx, "_outstanding"}, 64'(outstanding), 64'd0);
        checkOutput({pfx, "_tag_err"},     64'(tag_err), 64'd0);
        checkOutput({pfx, "_req_vpn"},     64'(l2tol2tlb_req_vpn), 64'd0);
        checkOutput({pfx, "_resp_ppn"},    64'(resp_ppn), 64'd0);
        checkOutput({pfx, "_resp_id"},     64'(resp_id), 64'd0);
    endtask

    // Assert reset between clock edges. Check the outputs clear at once,
    // then release reset on the next negedge.
    task automatic midReset(input string pfx);
        #2;
        reset = 1'b0;
        idleInputs();
        #1;
        checkResetValues(pfx);
        modelReset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Random protocol-respecting stimulus. A retried miss or ack stays
    // stable until it is accepted. The emulated l2tlb acks only tags it has
    // received, except for an occasional stray tag. A stray ack is sent only
    // when it cannot be retried.
    task automatic applyStimulus();
        int r;
        int bad;
        if (!miss_held) begin
            miss_valid = allow_miss && ($urandom_range(0, 9) < 6);
            miss_vpn   = VPN_W'($urandom);
            miss_id    = ID_W'($urandom);
        end
        l2tol2tlb_req_retry = ($urandom_range(0, 9) < 3);
        resp_retry          = ($urandom_range(0, 9) < 3);
        if (!ack_held) begin
            l2tlbtol2_ack_valid = 1'b0;
            r = $urandom_range(0, 99);
            if (l2q.size() > 0 && r < 55) begin
                l2tlbtol2_ack_valid = 1'b1;
                l2tlbtol2_ack_tag   = TAG_W'(l2q[$urandom_range(0, l2q.size() - 1)]);
                l2tlbtol2_ack_ppn   = PPN_W'($urandom);
                l2tlbtol2_ack_fault = ($urandom_range(0, 7) == 0);
            end else if (r >= 98 && !m_resp_valid && !resp_retry) begin
                bad = lowestFree();
                if (bad >= 0) begin
                    l2tlbtol2_ack_valid = 1'b1;
                    l2tlbtol2_ack_tag   = TAG_W'(bad);
                    l2tlbtol2_ack_ppn   = PPN_W'($urandom);
                    l2tlbtol2_ack_fault = 1'b0;
                end
            end
        end
    endtask

    initial begin
        idleInputs();
        reset = 1'b0;
        modelReset();
        allow_miss = 1'b1;
        repeat (2) @(negedge clk);
        checkResetValues("rst");
        reset = 1'b1;
        @(negedge clk);
        checkRegs();

        // Single miss, acked two cycles after the request transfer
        miss_valid = 1'b1; miss_vpn = 27'h1234; miss_id = 4'd3;
        tick();
        checkOutput("t1_req_valid", 64'(l2tol2tlb_req_valid), 64'd1);
        checkOutput("t1_req_tag", 64'(l2tol2tlb_req_tag), 64'd0);
        checkOutput("t1_req_vpn", 64'(l2tol2tlb_req_vpn), 64'h1234);
        checkOutput("t1_outstanding", 64'(outstanding), 64'd1);
        miss_valid = 1'b0;
        tick();
        tick();
        l2tlbtol2_ack_valid = 1'b1; l2tlbtol2_ack_tag = 2'd0;
        l2tlbtol2_ack_ppn = 26'h55; l2tlbtol2_ack_fault = 1'b0;
        tick();
        checkOutput("t1_resp_valid", 64'(resp_valid), 64'd1);
        checkOutput("t1_resp_id", 64'(resp_id), 64'd3);
        checkOutput("t1_resp_ppn", 64'(resp_ppn), 64'h55);
        checkOutput("t1_outstanding0", 64'(outstanding), 64'd0);
        l2tlbtol2_ack_valid = 1'b0;
        tick();
        checkOutput("t1_resp_drained", 64'(resp_valid), 64'd0);

        // Four back-to-back misses fill the tag table
        for (int i = 0; i < 4; i++) begin
            miss_valid = 1'b1; miss_vpn = VPN_W'(32'h100 + i); miss_id = ID_W'(i + 1);
            tick();
            checkOutput("t2_req_tag", 64'(l2tol2tlb_req_tag), 64'(i));
            checkOutput("t2_outstanding", 64'(outstanding), 64'(i + 1));
        end
        miss_vpn = 27'h104; miss_id = 4'd5;
        #1 checkOutput("t2_full_retry", 64'(miss_retry), 64'd1);
        tick();
        tick();
        l2tlbtol2_ack_valid = 1'b1; l2tlbtol2_ack_tag = 2'd2; l2tlbtol2_ack_ppn = 26'h200;
        #1 checkOutput("t2_retry_at_ack", 64'(miss_retry), 64'd1);
        tick();
        checkOutput("t3_resp_id_tag2", 64'(resp_id), 64'd3);
        l2tlbtol2_ack_tag = 2'd0; l2tlbtol2_ack_ppn = 26'h201;
        #1 checkOutput("t2_retry_released", 64'(miss_retry), 64'd0);
        tick();
        checkOutput("t2_fifth_tag", 64'(l2tol2tlb_req_tag), 64'd2);
        checkOutput("t3_resp_id_tag0", 64'(resp_id), 64'd1);
        checkOutput("t2_outstanding3", 64'(outstanding), 64'd3);
        miss_valid = 1'b0;
        l2tlbtol2_ack_tag = 2'd3; l2tlbtol2_ack_ppn = 26'h202;
        tick();
        checkOutput("t3_resp_id_tag3", 64'(resp_id), 64'd4);
        checkOutput("t3_resp_ppn_tag3", 64'(resp_ppn), 64'h202);
        l2tlbtol2_ack_tag = 2'd1; l2tlbtol2_ack_ppn = 26'h203;
        tick();
        checkOutput("t3_resp_id_tag1", 64'(resp_id), 64'd2);
        l2tlbtol2_ack_tag = 2'd2; l2tlbtol2_ack_ppn = 26'h204;
        tick();
        checkOutput("t3_resp_id_fifth", 64'(resp_id), 64'd5);
        checkOutput("t3_outstanding0", 64'(outstanding), 64'd0);
        l2tlbtol2_ack_valid = 1'b0;
        tick();

        // Request channel stalled for five cycles
        miss_valid = 1'b1; miss_vpn = 27'hABCDE; miss_id = 4'd7; l2tol2tlb_req_retry = 1'b1;
        tick();
        miss_vpn = 27'h777; miss_id = 4'd8;
        for (int i = 0; i < 5; i++) begin
            #1 checkOutput("t4_miss_retry", 64'(miss_retry), 64'd1);
            tick();
            checkOutput("t4_req_hold_valid", 64'(l2tol2tlb_req_valid), 64'd1);
            checkOutput("t4_req_hold_vpn", 64'(l2tol2tlb_req_vpn), 64'hABCDE);
        end
        l2tol2tlb_req_retry = 1'b0;
        tick();
        checkOutput("t4_next_vpn", 64'(l2tol2tlb_req_vpn), 64'h777);
        checkOutput("t4_next_tag", 64'(l2tol2tlb_req_tag), 64'd1);
        miss_valid = 1'b0;
        tick();

        // Response channel stalled while two acks arrive
        resp_retry = 1'b1;
        l2tlbtol2_ack_valid = 1'b1; l2tlbtol2_ack_tag = 2'd0; l2tlbtol2_ack_ppn = 26'h300;
        tick();
        checkOutput("t5_first_id", 64'(resp_id), 64'd7);
        l2tlbtol2_ack_tag = 2'd1; l2tlbtol2_ack_ppn = 26'h301;
        #1 checkOutput("t5_ack_retry", 64'(l2tlbtol2_ack_retry), 64'd1);
        tick();
        checkOutput("t5_first_held", 64'(resp_id), 64'd7);
        checkOutput("t5_outstanding1", 64'(outstanding), 64'd1);
        tick();
        resp_retry = 1'b0;
        tick();
        checkOutput("t5_second_id", 64'(resp_id), 64'd8);
        checkOutput("t5_second_ppn", 64'(resp_ppn), 64'h301);
        checkOutput("t5_outstanding0", 64'(outstanding), 64'd0);
        l2tlbtol2_ack_valid = 1'b0;
        tick();

        // Ack for an unallocated tag, then reset in the middle of traffic
        miss_valid = 1'b1; miss_vpn = 27'h55; miss_id = 4'd9;
        tick();
        miss_valid = 1'b0;
        tick();
        l2tlbtol2_ack_valid = 1'b1; l2tlbtol2_ack_tag = 2'd1; l2tlbtol2_ack_ppn = 26'h999;
        tick();
        checkOutput("t6_tag_err", 64'(tag_err), 64'd1);
        checkOutput("t6_no_resp", 64'(resp_valid), 64'd0);
        checkOutput("t6_outstanding1", 64'(outstanding), 64'd1);
        l2tlbtol2_ack_valid = 1'b0;
        miss_valid = 1'b1; miss_vpn = 27'h66; miss_id = 4'd10;
        tick();
        midReset("t6_mid");
        checkRegs();
        l2tlbtol2_ack_valid = 1'b1; l2tlbtol2_ack_tag = 2'd0; l2tlbtol2_ack_ppn = 26'h1;
        tick();
        checkOutput("t6_late_ack_err", 64'(tag_err), 64'd1);
        checkOutput("t6_late_ack_no_resp", 64'(resp_valid), 64'd0);
        l2tlbtol2_ack_valid = 1'b0;
        tick();
        midReset("t6_clean");
        checkRegs();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            applyStimulus();
            tick();
        end

        // Stop new misses and let every outstanding tag return
        allow_miss = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (modelCount() == 0 && !m_resp_valid && !m_req_valid && !miss_held) break;
            applyStimulus();
            tick();
        end
        checkOutput("drain_outstanding", 64'(outstanding), 64'd0);
        checkOutput("drain_resp_valid", 64'(resp_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
